rst_ctrl: RTL and testbench

System reset controller sitting directly downstream of the watchdog blocks on the Wishbone peripheral bus. Consumes the `rst_iwdg` / `rst_wwdg` pulses and a software reset request. Produces a stretched, glitch-free active-low system reset `sys_rst_n`. Records sticky reset-cause flags and a saturating watchdog-reset counter, both readable over Wishbone; these survive `sys_rst_n` because only `rst_m2s` clears them.

---
 rtl/rst_ctrl_pkg.sv | 18 +
 rtl/rst_sync_edge.sv | 34 +++
 rtl/rst_ctrl.sv | 122 ++++++++++++
 tb/tb_rst_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rst_ctrl_pkg.sv
// Shared constants for the reset controller: CSR bit positions, register offsets and FSM encodings.
package rst_ctrl_pkg;

  localparam int IWDGRSTF = 0;
  localparam int WWDGRSTF = 1;
  localparam int SFTRSTF  = 2;
  localparam int PORRSTF  = 3;
  localparam int RMVF     = 8;
  localparam int BUSY     = 9;
  localparam int SWRST    = 15;

  localparam logic [31:0] RST_CSR_OFS = 32'h0;
  localparam logic [31:0] RST_CNT_OFS = 32'h4;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} rst_state_e;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} bus_state_e;

endpackage

// File: rtl/rst_sync_edge.sv
// Rising-edge detector for one watchdog reset input.
// With RST_CTRL_SYNC_EN defined the input first passes a 2-flop synchronizer.
module rst_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic s;
  logic prev_q;

`ifdef RST_CTRL_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], d_i};
  end

  assign s = sync_q[1];
`else
  assign s = d_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= s;
  end

  // A held-high input produces a single event.
  assign rise_o = s & ~prev_q;

endmodule

// File: rtl/rst_ctrl.sv
// System reset controller: stretches watchdog/software reset events into sys_rst_n and keeps
// sticky cause flags plus a saturating watchdog counter on Wishbone. Option: RST_CTRL_SYNC_EN.
module rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h0100_0100,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_m2s,
  input  logic        rst_m2s,
  input  logic [15:0] dat_m2s,
  input  logic [31:0] adr_m2s,
  input  logic        cyc_m2s,
  input  logic        we_m2s,
  input  logic        stb_m2s,
  output logic [15:0] dat_s2m,
  output logic        ack_s2m,
  input  logic        rst_iwdg,
  input  logic        rst_wwdg,
  output logic        sys_rst_n
);

  localparam logic [31:0] RST_CSR_ADR = BASE_ADR + RST_CSR_OFS;
  localparam logic [31:0] RST_CNT_ADR = BASE_ADR + RST_CNT_OFS;
  localparam logic [7:0]  HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

  logic        iwdg_ev, wwdg_ev, wdg_ev, sw_ev, rmvf, csr_wr;
  rst_state_e  state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        sys_rst_n_q;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  cnt_q, cnt_d;
  bus_state_e  bus_q, bus_d;
  logic [31:0] adr_q;
  logic        we_q, swrst_q, rmvf_q;
  logic [15:0] rdata;
  logic        unused_dat;

  assign unused_dat = ^{dat_m2s[14:9], dat_m2s[7:0]};

  rst_sync_edge u_iwdg (.clk_i(clk_m2s), .rst_ni(rst_m2s), .d_i(rst_iwdg), .rise_o(iwdg_ev));
  rst_sync_edge u_wwdg (.clk_i(clk_m2s), .rst_ni(rst_m2s), .d_i(rst_wwdg), .rise_o(wwdg_ev));

  // Write side effects land on the edge that ends the ACK cycle.
  assign csr_wr = (bus_q == ACK) && we_q && (adr_q == RST_CSR_ADR);
  assign sw_ev  = csr_wr & swrst_q;
  assign rmvf   = csr_wr & rmvf_q;
  assign wdg_ev = iwdg_ev | wwdg_ev;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (wdg_ev || sw_ev) begin
      state_d = HOLD;
      hold_d  = HOLD_LOAD;
    end else if (state_q == HOLD) begin
      if (hold_q == 8'd0) state_d = RUN;
      else                hold_d  = hold_q - 8'd1;
    end
  end

  always_comb begin
    flags_d = rmvf ? 4'b0000 : flags_q;
    if (iwdg_ev) flags_d[IWDGRSTF] = 1'b1;
    if (wwdg_ev) flags_d[WWDGRSTF] = 1'b1;
    if (sw_ev)   flags_d[SFTRSTF]  = 1'b1;
    cnt_d = cnt_q;
    if (wdg_ev && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_m2s or negedge rst_m2s) begin
    if (!rst_m2s) begin
      state_q     <= HOLD;
      hold_q      <= HOLD_LOAD;
      sys_rst_n_q <= 1'b0;
      flags_q     <= 4'b1000;
      cnt_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      sys_rst_n_q <= (state_d == RUN);
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sys_rst_n = sys_rst_n_q;

  assign bus_d = (bus_q == IDLE && cyc_m2s && stb_m2s) ? ACK : IDLE;

  always_ff @(posedge clk_m2s or negedge rst_m2s) begin
    if (!rst_m2s) begin
      bus_q   <= IDLE;
      adr_q   <= 32'h0;
      we_q    <= 1'b0;
      swrst_q <= 1'b0;
      rmvf_q  <= 1'b0;
    end else begin
      bus_q <= bus_d;
      if (bus_q == IDLE) begin
        adr_q   <= adr_m2s;
        we_q    <= we_m2s;
        swrst_q <= dat_m2s[SWRST];
        rmvf_q  <= dat_m2s[RMVF];
      end
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (adr_q == RST_CSR_ADR) begin
      rdata[3:0]  = flags_q;
      rdata[BUSY] = (state_q == HOLD);
    end else if (adr_q == RST_CNT_ADR) begin
      rdata[7:0] = cnt_q;
    end
  end

  assign ack_s2m = (bus_q == ACK);
  assign dat_s2m = ack_s2m ? rdata : 16'h0000;

endmodule

// File: tb/tb_rst_ctrl.sv
// Directed bench for rst_ctrl: power-on, watchdog events, hold extension, SWRST/RMVF, saturation.
module tb_rst_ctrl;

`ifdef RST_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam logic [31:0] BASE = 32'h0100_0100;
  localparam logic [31:0] CSR  = BASE + 32'h0;
  localparam logic [31:0] CNT  = BASE + 32'h4;

  logic        clk_m2s = 1'b0;
  logic        rst_m2s;
  logic [15:0] dat_m2s;
  logic [31:0] adr_m2s;
  logic        cyc_m2s, we_m2s, stb_m2s;
  logic [15:0] dat_s2m;
  logic        ack_s2m;
  logic        rst_iwdg, rst_wwdg;
  logic        sys_rst_n;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_m2s = ~clk_m2s;

  rst_ctrl dut (
    .clk_m2s(clk_m2s), .rst_m2s(rst_m2s), .dat_m2s(dat_m2s), .adr_m2s(adr_m2s),
    .cyc_m2s(cyc_m2s), .we_m2s(we_m2s), .stb_m2s(stb_m2s), .dat_s2m(dat_s2m),
    .ack_s2m(ack_s2m), .rst_iwdg(rst_iwdg), .rst_wwdg(rst_wwdg), .sys_rst_n(sys_rst_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_m2s);
    #1;
  endtask

  task automatic wb(input logic we, input logic [31:0] adr, input logic [15:0] wd,
                    output logic [15:0] rd);
    logic got = 1'b0;
    rd = 16'h0;
    cyc_m2s = 1'b1; stb_m2s = 1'b1; we_m2s = we; adr_m2s = adr; dat_m2s = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      tick;
      if (ack_s2m) begin
        got = 1'b1;
        rd  = dat_s2m;
      end
    end
    cyc_m2s = 1'b0; stb_m2s = 1'b0; we_m2s = 1'b0;
    chk("ack_seen", {31'h0, got}, 32'h1);
    tick;
    chk("ack_one_cycle", {31'h0, ack_s2m}, 32'h0);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [15:0] d);
    wb(1'b0, adr, 16'h0, d);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [15:0] d);
    logic [15:0] dummy;
    wb(1'b1, adr, d, dummy);
  endtask

  // Edges until sys_rst_n is high again, counted from the current (low) cycle.
  task automatic wait_run(output int n);
    n = 0;
    while (!sys_rst_n && n < 400) begin
      tick;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    int n;
    rst_m2s = 1'b0; rst_iwdg = 1'b0; rst_wwdg = 1'b0;
    cyc_m2s = 1'b0; stb_m2s = 1'b0; we_m2s = 1'b0; adr_m2s = 32'h0; dat_m2s = 16'h0;

    // Power-on
    repeat (5) tick;
    chk("por_sysrst", {31'h0, sys_rst_n}, 32'h0);
    chk("por_ack", {31'h0, ack_s2m}, 32'h0);
    chk("por_dat", {16'h0, dat_s2m}, 32'h0);
    rst_m2s = 1'b1;
    wait_run(n);
    chk("por_hold", n, 16);
    rd(CSR, d); chk("por_csr", {16'h0, d}, 32'h0008);
    rd(CNT, d); chk("por_cnt", {16'h0, d}, 32'h0000);

    // Single IWDG pulse
    rst_iwdg = 1'b1; tick; rst_iwdg = 1'b0;
    repeat (LAT) tick;
    chk("iwdg_fall", {31'h0, sys_rst_n}, 32'h0);
    wait_run(n);
    chk("iwdg_hold", n, 16);
    rd(CSR, d); chk("iwdg_csr", {16'h0, d}, 32'h0009);
    rd(CNT, d); chk("iwdg_cnt", {16'h0, d}, 32'h0001);

    wr(CSR, 16'h0100);
    rd(CSR, d); chk("rmvf1_csr", {16'h0, d}, 32'h0000);

    // Simultaneous IWDG + WWDG counts once
    rst_iwdg = 1'b1; rst_wwdg = 1'b1; tick; rst_iwdg = 1'b0; rst_wwdg = 1'b0;
    repeat (LAT) tick;
    chk("both_fall", {31'h0, sys_rst_n}, 32'h0);
    wait_run(n);
    chk("both_hold", n, 16);
    rd(CSR, d); chk("both_csr", {16'h0, d}, 32'h0003);
    rd(CNT, d); chk("both_cnt", {16'h0, d}, 32'h0002);

    // Second WWDG 10 cycles into HOLD extends the reset
    rst_wwdg = 1'b1; tick; rst_wwdg = 1'b0;
    repeat (LAT) tick;
    chk("ext_fall", {31'h0, sys_rst_n}, 32'h0);
    repeat (9) tick;
    rst_wwdg = 1'b1; tick; rst_wwdg = 1'b0;
    chk("ext_still_low", {31'h0, sys_rst_n}, 32'h0);
    wait_run(n);
    chk("ext_hold", n + 10, 26 + LAT);
    rd(CNT, d); chk("ext_cnt", {16'h0, d}, 32'h0004);

    // Software reset: falls on the edge ending the ACK cycle
    chk("sw_pre_high", {31'h0, sys_rst_n}, 32'h1);
    wr(CSR, 16'h8000);
    chk("sw_fall", {31'h0, sys_rst_n}, 32'h0);
    rd(CSR, d); chk("sw_csr_busy", {16'h0, d}, 32'h0207);
    wait_run(n);
    chk("sw_hold_rest", n, 14);
    rd(CNT, d); chk("sw_cnt", {16'h0, d}, 32'h0004);
    wr(CSR, 16'h0100);
    rd(CSR, d); chk("rmvf2_csr", {16'h0, d}, 32'h0000);

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      rst_iwdg = 1'b1; tick; rst_iwdg = 1'b0;
      repeat (39) tick;
    end
    rd(CNT, d); chk("sat_cnt", {16'h0, d}, 32'h00FF);
    rd(CSR, d); chk("sat_csr", {16'h0, d}, 32'h0001);
    rd(BASE + 32'h8, d); chk("unmapped_rd", {16'h0, d}, 32'h0000);
    wr(CNT, 16'h0000);
    rd(CNT, d); chk("cnt_ro", {16'h0, d}, 32'h00FF);
    wr(BASE + 32'h8, 16'h8100);
    chk("unmapped_wr_nosw", {31'h0, sys_rst_n}, 32'h1);
    rd(CSR, d); chk("unmapped_wr_csr", {16'h0, d}, 32'h0001);

    // Reset asserted mid-HOLD restarts the full hold and clears state
    rst_iwdg = 1'b1; tick; rst_iwdg = 1'b0;
    repeat (LAT + 5) tick;
    rst_m2s = 1'b0; tick;
    chk("midrst_low", {31'h0, sys_rst_n}, 32'h0);
    rst_m2s = 1'b1;
    wait_run(n);
    chk("midrst_hold", n, 16);
    rd(CSR, d); chk("midrst_csr", {16'h0, d}, 32'h0008);
    rd(CNT, d); chk("midrst_cnt", {16'h0, d}, 32'h0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
